// File: rtl/rv32i_register_file.sv
// 32 x XLEN integer register file: two combinational read ports, one synchronous
// write port, x0 hard-wired to zero, synchronous active-high reset.
module rv32i_register_file #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32,
  localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_reg,
  input  logic [XLEN-1:0]   wr_data,
  input  logic [ADDR_W-1:0] rd_reg_1,
  input  logic [ADDR_W-1:0] rd_reg_2,
  output logic [XLEN-1:0]   rd_data_1,
  output logic [XLEN-1:0]   rd_data_2
);

  logic [XLEN-1:0] r_regs [NUM_REGS];
  logic            w_wr_fire;

  assign w_wr_fire = wr_en && (wr_reg != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_regs <= '{default: '0};
    end else if (w_wr_fire) begin
      r_regs[wr_reg] <= wr_data;
    end
  end

  // x0 is masked on the read side so it reads zero even before the first reset.
  always_comb begin
    rd_data_1 = '0;
    rd_data_2 = '0;
    if (rd_reg_1 != '0) rd_data_1 = r_regs[rd_reg_1];
    if (rd_reg_2 != '0) rd_data_2 = r_regs[rd_reg_2];
  end

endmodule

// Bound checker: x0 reads zero, and an accepted write is held on the next cycle.
module rv32i_register_file_sva #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32,
  localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
  input logic              clk,
  input logic              rst,
  input logic              wr_en,
  input logic [ADDR_W-1:0] wr_reg,
  input logic [XLEN-1:0]   wr_data,
  input logic [ADDR_W-1:0] rd_reg_1,
  input logic [ADDR_W-1:0] rd_reg_2,
  input logic [XLEN-1:0]   rd_data_1,
  input logic [XLEN-1:0]   rd_data_2,
  input logic [XLEN-1:0]   r_regs [NUM_REGS]
);

  logic              r_chk;
  logic [ADDR_W-1:0] r_chk_idx;
  logic [XLEN-1:0]   r_chk_data;

  always_ff @(posedge clk) begin
    r_chk      <= wr_en && !rst && (wr_reg != '0);
    r_chk_idx  <= wr_reg;
    r_chk_data <= wr_data;
  end

  // Storage is read before this edge's update, i.e. the value left by the previous write.
  always_ff @(posedge clk) begin
    if (r_chk) assert (r_regs[r_chk_idx] == r_chk_data);
    if (rd_reg_1 == '0) assert (rd_data_1 == '0);
    if (rd_reg_2 == '0) assert (rd_data_2 == '0);
  end

endmodule

bind rv32i_register_file rv32i_register_file_sva #(
  .XLEN(XLEN),
  .NUM_REGS(NUM_REGS)
) u_sva (
  .clk(clk),
  .rst(rst),
  .wr_en(wr_en),
  .wr_reg(wr_reg),
  .wr_data(wr_data),
  .rd_reg_1(rd_reg_1),
  .rd_reg_2(rd_reg_2),
  .rd_data_1(rd_data_1),
  .rd_data_2(rd_data_2),
  .r_regs(r_regs)
);

// File: tb/tb_rv32i_register_file.sv
// Directed and scored-random checks for rv32i_register_file.
module tb_rv32i_register_file;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic [4:0]  rd_reg_1;
  logic [4:0]  rd_reg_2;
  logic [31:0] rd_data_1;
  logic [31:0] rd_data_2;

  int unsigned n_checks;
  int unsigned n_pass;
  logic [31:0] m_regs [32];

  rv32i_register_file #(.XLEN(32), .NUM_REGS(32)) u_dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_reg(wr_reg),
    .wr_data(wr_data),
    .rd_reg_1(rd_reg_1),
    .rd_reg_2(rd_reg_2),
    .rd_data_1(rd_data_1),
    .rd_data_2(rd_data_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic en, input logic [4:0] idx, input logic [31:0] data);
    wr_en   = en;
    wr_reg  = idx;
    wr_data = data;
  endtask

  task automatic read2(input logic [4:0] a, input logic [4:0] b);
    rd_reg_1 = a;
    rd_reg_2 = b;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    drive_wr(1'b0, 5'd0, 32'h0);
    read2(5'd0, 5'd0);
    step();
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      read2(5'(i), 5'(31 - i));
      check($sformatf("reset_rd1_x%0d", i), rd_data_1, 32'h0);
      check($sformatf("reset_rd2_x%0d", 31 - i), rd_data_2, 32'h0);
    end

    drive_wr(1'b1, 5'd5, 32'hDEADBEEF);
    read2(5'd5, 5'd0);
    check("x5_same_cycle_old", rd_data_1, 32'h0);
    step();
    drive_wr(1'b0, 5'd0, 32'h0);
    read2(5'd5, 5'd5);
    check("x5_rd1_after", rd_data_1, 32'hDEADBEEF);
    check("x5_rd2_after", rd_data_2, 32'hDEADBEEF);

    drive_wr(1'b1, 5'd15, 32'hFFFF0000);
    step();
    read2(5'd15, 5'd15);
    check("x15_first_rd1", rd_data_1, 32'hFFFF0000);
    check("x15_first_rd2", rd_data_2, 32'hFFFF0000);
    drive_wr(1'b1, 5'd15, 32'h0000FFFF);
    #1;
    check("x15_second_pre_edge", rd_data_1, 32'hFFFF0000);
    step();
    drive_wr(1'b0, 5'd15, 32'hAAAAAAAA);
    read2(5'd15, 5'd5);
    check("x15_second", rd_data_1, 32'h0000FFFF);
    check("x5_unchanged", rd_data_2, 32'hDEADBEEF);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("x15_hold_%0d", c), rd_data_1, 32'h0000FFFF);
      check($sformatf("x5_hold_%0d", c), rd_data_2, 32'hDEADBEEF);
    end

    drive_wr(1'b1, 5'd0, 32'hFFFFFFFF);
    step();
    drive_wr(1'b0, 5'd0, 32'h0);
    read2(5'd0, 5'd0);
    check("x0_rd1", rd_data_1, 32'h0);
    check("x0_rd2", rd_data_2, 32'h0);

    drive_wr(1'b0, 5'd20, 32'h12345678);
    step();
    read2(5'd20, 5'd20);
    check("x20_no_wr_en", rd_data_1, 32'h0);

    drive_wr(1'b1, 5'd3, 32'hA5A5A5A5);
    step();
    read2(5'd3, 5'd7);
    check("x3_written", rd_data_1, 32'hA5A5A5A5);
    rst = 1'b1;
    drive_wr(1'b1, 5'd7, 32'h11111111);
    step();
    rst = 1'b0;
    drive_wr(1'b0, 5'd0, 32'h0);
    read2(5'd3, 5'd7);
    check("x3_after_rst", rd_data_1, 32'h0);
    check("x7_after_rst", rd_data_2, 32'h0);
    read2(5'd5, 5'd15);
    check("x5_after_rst", rd_data_1, 32'h0);
    check("x15_after_rst", rd_data_2, 32'h0);

    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    // First 32 cycles sweep every index with a same-cycle read/write hit; then random.
    for (int n = 0; n < 1000; n++) begin
      logic [31:0] exp1, exp2;
      if (n < 32) begin
        drive_wr(1'b1, 5'(n), $urandom);
        rd_reg_1 = 5'(n);
        rd_reg_2 = 5'(31 - n);
      end else begin
        drive_wr(($urandom_range(3) != 0), 5'($urandom_range(31)), $urandom);
        rd_reg_1 = 5'($urandom_range(31));
        rd_reg_2 = 5'($urandom_range(31));
      end
      #1;
      exp1 = (rd_reg_1 == 5'd0) ? 32'h0 : m_regs[rd_reg_1];
      exp2 = (rd_reg_2 == 5'd0) ? 32'h0 : m_regs[rd_reg_2];
      check($sformatf("rand%0d_rd1_x%0d", n, rd_reg_1), rd_data_1, exp1);
      check($sformatf("rand%0d_rd2_x%0d", n, rd_reg_2), rd_data_2, exp2);
      @(posedge clk);
      if (wr_en && wr_reg != 5'd0) m_regs[wr_reg] = wr_data;
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
